// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: FSM state encoding and ALU opcodes.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arbState_t;

  localparam logic [7:0] ALU_ADD  = 8'h00;
  localparam logic [7:0] ALU_SUB  = 8'h01;
  localparam logic [7:0] ALU_XOR  = 8'h02;
  localparam logic [7:0] ALU_OR   = 8'h04;
  localparam logic [7:0] ALU_AND  = 8'h08;
  localparam logic [7:0] ALU_SLL  = 8'h10;
  localparam logic [7:0] ALU_SRL  = 8'h20;
  localparam logic [7:0] ALU_SRA  = 8'h40;
  localparam logic [7:0] ALU_ANDN = 8'h80;
  localparam logic [7:0] ALU_EQ   = 8'h03;
  localparam logic [7:0] ALU_NE   = 8'h05;
  localparam logic [7:0] ALU_LTU  = 8'h09;
  localparam logic [7:0] ALU_GEU  = 8'h11;
  localparam logic [7:0] ALU_LT   = 8'h21;
  localparam logic [7:0] ALU_GE   = 8'h41;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 32-bit ALU shared by all requesters of alu_arbiter.
// Compare opcodes return 0/1; unknown opcodes return zero.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [7:0]  i_opcode,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  output logic [31:0] o_result
);

  // Decode the opcode and compute the single selected operation
  always_comb begin
    o_result = '0;
    case (i_opcode)
      ALU_ADD:  o_result = i_op1 + i_op2;
      ALU_SUB:  o_result = i_op1 - i_op2;
      ALU_XOR:  o_result = i_op1 ^ i_op2;
      ALU_OR:   o_result = i_op1 | i_op2;
      ALU_AND:  o_result = i_op1 & i_op2;
      ALU_SLL:  o_result = i_op1 << i_op2[4:0];
      ALU_SRL:  o_result = i_op1 >> i_op2[4:0];
      ALU_SRA:  o_result = 32'($signed(i_op1) >>> i_op2[4:0]);
      ALU_ANDN: o_result = i_op1 & ~i_op2;
      ALU_EQ:   o_result = {31'd0, i_op1 == i_op2};
      ALU_NE:   o_result = {31'd0, i_op1 != i_op2};
      ALU_LTU:  o_result = {31'd0, i_op1 < i_op2};
      ALU_GEU:  o_result = {31'd0, i_op1 >= i_op2};
      ALU_LT:   o_result = {31'd0, $signed(i_op1) < $signed(i_op2)};
      ALU_GE:   o_result = {31'd0, $signed(i_op1) >= $signed(i_op2)};
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters, one op in
// flight, registered result. Optional statistics counters are built when the
// macro ALU_ARBITER_STAT_EN is defined.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
)
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [8*NUM_REQ-1:0]    req_opcode,
  input  logic [XLEN*NUM_REQ-1:0] req_op1,
  input  logic [XLEN*NUM_REQ-1:0] req_op2,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]         rsp_result
`ifdef ALU_ARBITER_STAT_EN
  ,
  output logic [32*NUM_REQ-1:0]   stat_grant_cnt,
  output logic [31:0]             stat_wait_cnt
`endif
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arbState_t         r_state;
  arbState_t         w_nextState;
  logic [IDXW-1:0]   r_owner;
  logic [IDXW-1:0]   r_rrPtr;
  logic [7:0]        r_opcode;
  logic [XLEN-1:0]   r_op1;
  logic [XLEN-1:0]   r_op2;
  logic [XLEN-1:0]   r_result;
  logic              w_found;
  logic [IDXW-1:0]   w_grant;
  logic              w_handshake;
  logic [7:0]        w_selOpcode;
  logic [XLEN-1:0]   w_selOp1;
  logic [XLEN-1:0]   w_selOp2;
  logic [XLEN-1:0]   w_aluResult;

  // First valid requester after ptr, wrapping; MSB of the return flags a hit
  function automatic logic [IDXW:0] rrPick(input logic [NUM_REQ-1:0] valid,
                                           input logic [IDXW-1:0]    ptr);
    logic            found;
    logic [IDXW-1:0] grant;
    int              idx;
    found = 1'b0;
    grant = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && valid[idx]) begin
        found = 1'b1;
        grant = IDXW'(idx);
      end
    end
    return {found, grant};
  endfunction

  assign {w_found, w_grant} = rrPick(req_valid, r_rrPtr);
  assign w_handshake        = (r_state == ST_IDLE) && w_found;
  assign rsp_result         = r_result;

  // Select the granted requester's payload for latching at the handshake
  always_comb begin
    w_selOpcode = '0;
    w_selOp1    = '0;
    w_selOp2    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == IDXW'(i)) begin
        w_selOpcode = req_opcode[i*8 +: 8];
        w_selOp1    = req_op1[i*XLEN +: XLEN];
        w_selOp2    = req_op2[i*XLEN +: XLEN];
      end
    end
  end

  alu_arbiter_alu uAlu (
    .i_opcode (r_opcode),
    .i_op1    (r_op1),
    .i_op2    (r_op2),
    .o_result (w_aluResult)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic: grant in IDLE, one execute cycle, hold until owner accepts
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (w_found) w_nextState = ST_EXEC;
      ST_EXEC: w_nextState = ST_RESP;
      ST_RESP: if (rsp_ready[r_owner]) w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Outputs: one-hot ready on the grant in IDLE, valid to the owner in RESP
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (reset && (r_state == ST_IDLE) && w_found) req_ready[w_grant] = 1'b1;
    if (r_state == ST_RESP) rsp_valid[r_owner] = 1'b1;
  end

  // Latch payload and owner at the handshake; capture the ALU result in EXEC
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_owner  <= '0;
      r_rrPtr  <= IDXW'(NUM_REQ - 1);
      r_opcode <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_result <= '0;
    end else begin
      if (w_handshake) begin
        r_owner  <= w_grant;
        r_rrPtr  <= w_grant;
        r_opcode <= w_selOpcode;
        r_op1    <= w_selOp1;
        r_op2    <= w_selOp2;
      end
      if (r_state == ST_EXEC) r_result <= w_aluResult;
    end
  end

`ifdef ALU_ARBITER_STAT_EN
  logic [32*NUM_REQ-1:0] r_grantCnt;
  logic [31:0]           r_waitCnt;

  // Per-requester grant counts and cycles where some request is left waiting
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_grantCnt <= '0;
      r_waitCnt  <= '0;
    end else begin
      if (w_handshake) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (w_grant == IDXW'(i)) r_grantCnt[i*32 +: 32] <= r_grantCnt[i*32 +: 32] + 32'd1;
        end
      end
      if (|(req_valid & ~req_ready)) r_waitCnt <= r_waitCnt + 32'd1;
    end
  end

  assign stat_grant_cnt = r_grantCnt;
  assign stat_wait_cnt  = r_waitCnt;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with hand-computed results.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int NUM_REQ = 2;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [8*NUM_REQ-1:0]  req_opcode = '0;
  logic [32*NUM_REQ-1:0] req_op1 = '0;
  logic [32*NUM_REQ-1:0] req_op2 = '0;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready = '0;
  logic [31:0]           rsp_result;
`ifdef ALU_ARBITER_STAT_EN
  logic [32*NUM_REQ-1:0] stat_grant_cnt;
  logic [31:0]           stat_wait_cnt;
`endif

  int vectorCount = 0;
  int missCount   = 0;

  typedef struct {
    int          idx;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  alu_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result)
`ifdef ALU_ARBITER_STAT_EN
    ,
    .stat_grant_cnt (stat_grant_cnt),
    .stat_wait_cnt  (stat_wait_cnt)
`endif
  );

  // Free-running clock, 10 time units per period
  always #5 clock = ~clock;

  // Count one comparison and report it if observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Place a payload on requester idx's channel
  task automatic setReq(input int idx, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    req_opcode[idx*8 +: 8]  = op;
    req_op1[idx*32 +: 32]   = a;
    req_op2[idx*32 +: 32]   = b;
  endtask

  // One complete single-requester transaction with all its checks
  task automatic applyStimulus(input string tag, input int idx, input logic [7:0] op,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    logic [NUM_REQ-1:0] oneHot;
    oneHot = '0;
    oneHot[idx] = 1'b1;
    setReq(idx, op, a, b);
    req_valid = oneHot;
    #1;
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'(oneHot));
    tick();
    req_valid = '0;
    #1;
    checkOutput({tag, "_execValid"}, 32'(rsp_valid), 32'd0);
    tick();
    checkOutput({tag, "_rspValid"}, 32'(rsp_valid), 32'(oneHot));
    checkOutput({tag, "_result"}, rsp_result, exp);
    rsp_ready = oneHot;
    tick();
    rsp_ready = '0;
    #1;
    checkOutput({tag, "_rspDone"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    vecs = '{
      '{0, ALU_ADD,  32'd5,        32'd7,        32'd12},
      '{1, ALU_SUB,  32'd3,        32'd5,        32'hFFFFFFFE},
      '{0, ALU_LT,   32'hFFFFFFFF, 32'd1,        32'd1},
      '{0, ALU_LTU,  32'hFFFFFFFF, 32'd1,        32'd0},
      '{1, ALU_XOR,  32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5},
      '{0, ALU_OR,   32'h000000F0, 32'h0000000F, 32'h000000FF},
      '{1, ALU_AND,  32'h000000FF, 32'h0000003C, 32'h0000003C},
      '{0, ALU_SLL,  32'd3,        32'd4,        32'h00000030},
      '{1, ALU_SRL,  32'h80000000, 32'd4,        32'h08000000},
      '{0, ALU_SRA,  32'h80000000, 32'd4,        32'hF8000000},
      '{1, ALU_ANDN, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF000F000},
      '{0, ALU_EQ,   32'd7,        32'd7,        32'd1},
      '{1, ALU_NE,   32'd7,        32'd7,        32'd0},
      '{0, ALU_GEU,  32'd1,        32'hFFFFFFFF, 32'd0},
      '{1, ALU_GE,   32'hFFFFFFFF, 32'd1,        32'd0},
      '{0, ALU_ADD,  32'hFFFFFFFF, 32'd2,        32'd1}
    };

    // Reset state
    #3;
    checkOutput("rst_reqReady", 32'(req_ready), 32'd0);
    checkOutput("rst_rspValid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_result", rsp_result, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Directed single-requester vectors
    for (int i = 0; i < 16; i++)
      applyStimulus($sformatf("vec%0d", i), vecs[i].idx, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Round-robin from reset: both requesters held valid, grants alternate 0,1,0,1
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    setReq(0, ALU_ADD, 32'd10, 32'd20);
    setReq(1, ALU_SUB, 32'd50, 32'd8);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic [1:0]  expHot;
      logic [31:0] expRes;
      expHot = (k % 2 == 0) ? 2'b01 : 2'b10;
      expRes = (k % 2 == 0) ? 32'd30 : 32'd42;
      #1;
      checkOutput($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(expHot));
      tick();
      checkOutput($sformatf("rr%0d_execReady", k), 32'(req_ready), 32'd0);
      tick();
      checkOutput($sformatf("rr%0d_rspValid", k), 32'(rsp_valid), 32'(expHot));
      checkOutput($sformatf("rr%0d_result", k), rsp_result, expRes);
      rsp_ready = expHot;
      tick();
      rsp_ready = '0;
    end
    req_valid = '0;

    // Response stall: owner holds off, non-owner ready ignored, pending req1 waits
    setReq(0, ALU_XOR, 32'hA5A5A5A5, 32'hFFFF0000);
    req_valid = 2'b01;
    tick();
    setReq(1, ALU_SUB, 32'd9, 32'd4);
    req_valid = 2'b10;
    #1;
    checkOutput("stall_execReady", 32'(req_ready), 32'd0);
    tick();
    rsp_ready = 2'b10;
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("stall%0d_valid", k), 32'(rsp_valid), 32'h1);
      checkOutput($sformatf("stall%0d_result", k), rsp_result, 32'h5A5AA5A5);
      checkOutput($sformatf("stall%0d_ready", k), 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = '0;
    #1;
    checkOutput("stall_release_valid", 32'(rsp_valid), 32'd0);
    checkOutput("stall_release_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    checkOutput("stall_req1_valid", 32'(rsp_valid), 32'h2);
    checkOutput("stall_req1_result", rsp_result, 32'd5);
    rsp_ready = 2'b10;
    tick();
    rsp_ready = '0;

    // Asynchronous reset during EXEC drops the op and restarts arbitration at req0
    setReq(1, ALU_ADD, 32'd1, 32'd1);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b11;
    #1;
    reset = 1'b0;
    #1;
    checkOutput("arst_reqReady", 32'(req_ready), 32'd0);
    checkOutput("arst_rspValid", 32'(rsp_valid), 32'd0);
    checkOutput("arst_result", rsp_result, 32'd0);
    tick();
    tick();
    checkOutput("arst_hold_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    setReq(0, ALU_ADD, 32'd40, 32'd2);
    #1;
    checkOutput("arst_firstGrant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();
    checkOutput("arst_rspValid2", 32'(rsp_valid), 32'h1);
    checkOutput("arst_result2", rsp_result, 32'd42);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU between NUM_REQ requesters, e.g. EXU integer ops and LSU/branch address or compare ops.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; one op in flight; the result is registered.
- Sits between the issuing units and the ALU datapath, which it instantiates.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- XLEN, 32, operand/result width; fixed at 32 by the ALU.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle.
- req_opcode  in  8*NUM_REQ  packed 8-bit ALU opcodes; requester i uses bits [8i+7:8i].
- req_op1  in  32*NUM_REQ  packed operand1.
- req_op2  in  32*NUM_REQ  packed operand2.
- rsp_valid  out  NUM_REQ  result valid for that requester; at most one bit set.
- rsp_ready  in  NUM_REQ  requester accepts result.
- rsp_result  out  32  shared result bus; meaningful only with a set rsp_valid bit.

Behaviour:
- Reset (reset=0, async): state=IDLE; req_ready=0, rsp_valid=0, rsp_result=0, owner=0, rr_ptr=NUM_REQ-1 (requester 0 wins first). Any in-flight op is dropped and produces no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant = first i with req_valid[i], scanning from (rr_ptr+1) mod NUM_REQ, wrapping.
  - req_ready is one-hot on the grant, combinational from req_valid and rr_ptr only.
  - On handshake: latch opcode/op1/op2, set owner=grant and rr_ptr=grant, go to EXEC.
  - No request: stay in IDLE.
- EXEC:
  - ALU is driven from the latched operands only.
  - rsp_result <= ALU result; go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid[owner]=1; rsp_result held stable.
  - On rsp_ready[owner]=1: rsp_valid cleared next cycle, go to IDLE.
  - rsp_ready of non-owners is ignored; req_ready=0.
- Latency: accept at cycle t, rsp_valid at t+2. Throughput: one op per 3 cycles, plus response stall cycles.
- req_valid held while not ready: payload must stay stable (requester rule). The arbiter does not check this; it samples only in the handshake cycle.
- req_valid dropped before grant: no effect, no state change.
- Opcode handling: passed unmodified to the ALU.
  - bit0=1 with bits[7:1]=0 is subtract.
  - bit0=1 with a single select bit set is compare, result 0/1.
  - Illegal opcodes produce whatever the ALU produces; no error flag.
- Arithmetic: 32-bit; add/sub wrap modulo 2^32.
- Simultaneous events:
  - New requests arriving during EXEC/RESP wait.
  - The arbitration decision is made only in IDLE.
  - A requester re-requesting in the cycle after its response competes normally under round-robin.

Optional Feature:
- Macro ALU_ARBITER_STAT_EN.
- Defined:
  - Extra output port stat_grant_cnt (32*NUM_REQ): per-requester 32-bit grant counters, +1 on each handshake.
  - Extra output port stat_wait_cnt (32): +1 every cycle in which any req_valid bit is set without a corresponding req_ready.
  - All counters reset to 0 and wrap at 2^32.
- Undefined: neither port nor any counter logic exists; behaviour is otherwise identical.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
  - ALU opcode constants: ADD=8'h00, SUB=8'h01, XOR=8'h02, OR=8'h04, AND=8'h08, SLL=8'h10, SRL=8'h20, SRA=8'h40, ANDN=8'h80, EQ=8'h03, NE=8'h05, LTU=8'h09, GEU=8'h11, LT=8'h21, GE=8'h41.
- Sub-module: the existing ALU instantiated once. The round-robin pick is a local function, not a separate module.

Test Plan:
- Req0 ADD, op1=5, op2=7, accepted at cycle t -> rsp_valid[0] at t+2, rsp_result=32'd12.
- Req1 SUB, op1=3, op2=5 -> rsp_result=32'hFFFFFFFE on rsp_valid[1] only; rsp_valid[0] stays 0.
- Req0 LT (8'h21), op1=32'hFFFFFFFF, op2=1 -> result 1. LTU (8'h09) on the same operands -> result 0.
- Both req_valid held high for 4 ops from reset -> grant order 0,1,0,1; each response on the matching rsp_valid bit.
- rsp_ready[owner] low for 5 cycles in RESP -> rsp_valid and rsp_result stable; req_ready=0 throughout; a pending req1 is granted only after release.
- reset deasserted→asserted during EXEC -> all outputs 0 immediately, no response; next op after reset is granted to req0 first.
